// File: rtl/inner_prod_if.sv
// Stream/result bundle between the vector source, coefficient memory and inner_prod.
interface inner_prod_if #(
    parameter int pcw = 10
);
    logic                    start;
    logic signed [17:0]      x;
    logic signed [17:0]      k_out;
    logic        [pcw-1:0]   k_out_addr;
    logic                    run;
    logic signed [17:0]      result;
    logic                    result_valid;

    modport master (
        output start, x, k_out,
        input  k_out_addr, run, result, result_valid
    );

    modport slave (
        input  start, x, k_out,
        output k_out_addr, run, result, result_valid
    );
endinterface

// File: rtl/inner_prod.sv
// Dot product of a streamed vector x with coefficients k, shifted and saturated to 18 bits.
// Result strobes 4 cycles after the last element; no backpressure, start restarts at any time.
module inner_prod #(
    parameter int pcw   = 10,
    parameter int nlen  = 1024,
    parameter int shift = 17
) (
    input  logic          clk,
    input  logic          rst,
    inner_prod_if.slave   bus
);
    localparam int aw = 36 + pcw;
    localparam logic [pcw-1:0]       last_pc = pcw'(nlen - 1);
    localparam logic signed [aw-1:0] pos_max = aw'(131071);
    localparam logic signed [aw-1:0] neg_min = aw'(-131072);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [pcw-1:0]     pc;
    logic               run_q;

    logic signed [17:0] x_a;
    logic               vld_a, first_a, last_a;
    logic signed [35:0] prod;
    logic               vld_b, first_b, last_b;
    logic signed [aw-1:0] acc;
    logic               last_c;
    logic signed [aw-1:0] shifted;
    logic signed [17:0] sat;
    logic signed [17:0] result_q;
    logic               result_valid_q;

    assign bus.k_out_addr   = pc;
    assign bus.run          = run_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

    // start always wins, so a restart or a back-to-back vector begins at pc=0 next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            run_q <= 1'b0;
        end else if (bus.start) begin
            state <= RUN;
            pc    <= '0;
            run_q <= 1'b1;
        end else if (state == RUN) begin
            if (pc == last_pc) begin
                state <= IDLE;
                pc    <= '0;
                run_q <= 1'b0;
            end else begin
                pc    <= pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_a     <= '0;
            vld_a   <= 1'b0;
            first_a <= 1'b0;
            last_a  <= 1'b0;
            prod    <= '0;
            vld_b   <= 1'b0;
            first_b <= 1'b0;
            last_b  <= 1'b0;
            acc     <= '0;
            last_c  <= 1'b0;
        end else begin
            x_a     <= bus.x;
            vld_a   <= run_q;
            first_a <= run_q && (pc == '0);
            last_a  <= run_q && (pc == last_pc);

            // 36-bit product still holds (-2^17)*(-2^17) = 2^34
            prod    <= 36'(bus.k_out) * 36'(x_a);
            vld_b   <= vld_a;
            first_b <= first_a;
            last_b  <= last_a;

            if (vld_b)
                acc <= first_b ? aw'(prod) : acc + aw'(prod);
            last_c  <= vld_b && last_b;
        end
    end

    assign shifted = acc >>> shift;

    always_comb begin
        sat = shifted[17:0];
        if (shifted > pos_max)
            sat = 18'h1FFFF;
        else if (shifted < neg_min)
            sat = 18'h20000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= last_c;
            if (last_c)
                result_q <= sat;
        end
    end
endmodule
